bus_reg_bank: RTL and testbench

- Parametrised successor to the single 16-bit bus register.
- Holds NREGS registers of WIDTH bits, loaded from a shared input bus.
- Each register can be loaded, incremented, decremented or cleared.
- Any one register drives a shared tri-state output bus. A read-side state machine inserts bus-turnaround cycles so two drivers never overlap.
- Sits between the datapath bus and the ALU/accumulator side of the microcontroller.

---
 rtl/bus_reg_bank.sv | 159 +++++++++++++++
 tb/tb_bus_reg_bank.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/bus_reg_bank.sv
// Bank of NREGS registers loaded from a shared input bus, with one register
// at a time presented on a shared tri-state output bus. A small read FSM
// inserts TURN Hi-Z cycles before every new drive so two bus drivers never
// overlap.
module bus_reg_bank #(
    parameter int WIDTH = 16,
    parameter int NREGS = 4,
    parameter int TURN  = 1,
    localparam int SEL_W = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in,
    input  logic             wr_en,
    input  logic [SEL_W-1:0] wr_sel,
    input  logic [1:0]       wr_op,
    input  logic             rd_en,
    input  logic [SEL_W-1:0] rd_sel,
    output logic [WIDTH-1:0] q,
    output logic             q_drv,
    output logic             sel_err
);

    typedef enum logic [1:0] {
        OP_LOAD = 2'b00,
        OP_INC  = 2'b01,
        OP_DEC  = 2'b10,
        OP_CLR  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_TURN,
        S_DRIVE
    } state_e;

    // Turnaround counter reload value; unused when TURN is 0.
    localparam logic [1:0] TURN_LD = (TURN > 0) ? 2'(TURN - 1) : 2'd0;

    logic [WIDTH-1:0] r_regs [NREGS];
    state_e           r_state;
    state_e           w_state_nxt;
    logic [1:0]       r_cnt;
    logic [1:0]       w_cnt_nxt;
    logic [SEL_W-1:0] r_cur_sel;
    logic [SEL_W-1:0] w_cur_sel_nxt;
    logic             r_sel_err;
    logic             w_wr_oob;
    logic             w_rd_oob;
    logic             w_drive;
    logic [WIDTH-1:0] w_rd_data;

    assign w_wr_oob = (32'(wr_sel) >= 32'(NREGS));
    assign w_rd_oob = (32'(rd_sel) >= 32'(NREGS));

    // Register array write path: one operation on the selected register per cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_regs <= '{default: '0};
        end else if (wr_en && !w_wr_oob) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                if (wr_sel == SEL_W'(i)) begin
                    case (op_e'(wr_op))
                        OP_LOAD: r_regs[i] <= in;
                        OP_INC:  r_regs[i] <= r_regs[i] + WIDTH'(1);
                        OP_DEC:  r_regs[i] <= r_regs[i] - WIDTH'(1);
                        default: r_regs[i] <= '0;
                    endcase
                end
            end
        end
    end

    // Sticky flag for any out-of-range select seen on an active strobe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sel_err <= 1'b0;
        end else if ((wr_en && w_wr_oob) || (rd_en && w_rd_oob)) begin
            r_sel_err <= 1'b1;
        end
    end

    // Read mux; an out-of-range current select matches nothing and reads zero.
    always_comb begin
        w_rd_data = '0;
        for (int unsigned i = 0; i < NREGS; i++) begin
            if (r_cur_sel == SEL_W'(i)) begin
                w_rd_data = r_regs[i];
            end
        end
    end

    // Read FSM state register, with its turnaround counter and latched select.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_cur_sel <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_cur_sel <= w_cur_sel_nxt;
        end
    end

    // Read FSM next-state: a select change always restarts the turnaround.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_cur_sel_nxt = r_cur_sel;
        case (r_state)
            S_IDLE: begin
                if (rd_en) begin
                    w_cur_sel_nxt = rd_sel;
                    if (TURN == 0) begin
                        w_state_nxt = S_DRIVE;
                    end else begin
                        w_cnt_nxt   = TURN_LD;
                        w_state_nxt = S_TURN;
                    end
                end
            end
            S_TURN: begin
                if (!rd_en) begin
                    w_state_nxt = S_IDLE;
                end else if (rd_sel != r_cur_sel) begin
                    w_cur_sel_nxt = rd_sel;
                    w_cnt_nxt     = TURN_LD;
                end else if (r_cnt == 2'd0) begin
                    w_state_nxt = S_DRIVE;
                end else begin
                    w_cnt_nxt = r_cnt - 2'd1;
                end
            end
            S_DRIVE: begin
                if (!rd_en) begin
                    w_state_nxt = S_IDLE;
                end else if (rd_sel != r_cur_sel) begin
                    w_cur_sel_nxt = rd_sel;
                    if (TURN != 0) begin
                        w_cnt_nxt   = TURN_LD;
                        w_state_nxt = S_TURN;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Read FSM outputs: bus enable comes from the state register only.
    always_comb begin
        w_drive = (r_state == S_DRIVE);
    end

    assign q       = w_drive ? w_rd_data : 'z;
    assign q_drv   = w_drive;
    assign sel_err = r_sel_err;

endmodule

// File: tb/tb_bus_reg_bank.sv
// Directed bench for bus_reg_bank: three builds share one stimulus stream
// (default, NREGS=3, TURN=3); each step checks the build it targets.
module tb_bus_reg_bank;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] in;
    logic        wr_en;
    logic [1:0]  wr_sel;
    logic [1:0]  wr_op;
    logic        rd_en;
    logic [1:0]  rd_sel;

    wire  [15:0] q_a, q_b, q_c;
    logic        qdrv_a, qdrv_b, qdrv_c;
    logic        err_a, err_b, err_c;

    int n_chk  = 0;
    int n_fail = 0;

    bus_reg_bank #(.WIDTH(16), .NREGS(4), .TURN(1)) dut_a (
        .clk(clk), .reset(reset), .in(in), .wr_en(wr_en), .wr_sel(wr_sel),
        .wr_op(wr_op), .rd_en(rd_en), .rd_sel(rd_sel),
        .q(q_a), .q_drv(qdrv_a), .sel_err(err_a)
    );

    bus_reg_bank #(.WIDTH(16), .NREGS(3), .TURN(1)) dut_b (
        .clk(clk), .reset(reset), .in(in), .wr_en(wr_en), .wr_sel(wr_sel),
        .wr_op(wr_op), .rd_en(rd_en), .rd_sel(rd_sel),
        .q(q_b), .q_drv(qdrv_b), .sel_err(err_b)
    );

    bus_reg_bank #(.WIDTH(16), .NREGS(4), .TURN(3)) dut_c (
        .clk(clk), .reset(reset), .in(in), .wr_en(wr_en), .wr_sel(wr_sel),
        .wr_op(wr_op), .rd_en(rd_en), .rd_sel(rd_sel),
        .q(q_c), .q_drv(qdrv_c), .sel_err(err_c)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] sel, input logic [1:0] op, input logic [15:0] d);
        in     = d;
        wr_sel = sel;
        wr_op  = op;
        wr_en  = 1'b1;
        tick();
        wr_en  = 1'b0;
    endtask

    // TURN=1 builds: Hi-Z after the first edge, driven after the second.
    task automatic rd_start(input logic [1:0] sel);
        rd_en  = 1'b1;
        rd_sel = sel;
        tick();
        chk("turn_hiz", {31'd0, qdrv_a}, 32'd0);
        tick();
    endtask

    task automatic rd_stop();
        rd_en = 1'b0;
        tick();
        chk("release", {31'd0, qdrv_a}, 32'd0);
    endtask

    initial begin
        reset = 1'b0; in = '0; wr_en = 1'b0; wr_sel = '0; wr_op = '0;
        rd_en = 1'b0; rd_sel = '0;
        #2;
        chk("rst_qdrv_a", {31'd0, qdrv_a}, 32'd0);
        chk("rst_err_b",  {31'd0, err_b},  32'd0);
        chk("rst_qdrv_c", {31'd0, qdrv_c}, 32'd0);
        tick(); tick();
        reset = 1'b1;

        // 1: async reset while driving, then every register reads zero
        wr(2'd1, 2'b00, 16'h7777);
        rd_start(2'd1);
        chk("pre_rst_q", q_a, 32'h7777);
        chk("pre_rst_drv", {31'd0, qdrv_a}, 32'd1);
        #3 reset = 1'b0;
        #1 chk("async_rst_drv", {31'd0, qdrv_a}, 32'd0);
        #2 reset = 1'b1; rd_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rd_start(2'(i));
            chk("rst_reg_zero", q_a, 32'h0000);
            chk("rst_reg_drv", {31'd0, qdrv_a}, 32'd1);
            rd_stop();
        end

        // 2: write operations with wrap-around
        wr(2'd0, 2'b00, 16'h1234);
        wr(2'd1, 2'b00, 16'hABCD);
        wr(2'd3, 2'b00, 16'h0005);
        wr(2'd2, 2'b00, 16'hFFFF);
        rd_start(2'd2); chk("load_ffff", q_a, 32'hFFFF); rd_stop();
        wr(2'd2, 2'b01, 16'h0000);
        rd_start(2'd2); chk("inc_wrap", q_a, 32'h0000); rd_stop();
        wr(2'd2, 2'b10, 16'h0000);
        rd_start(2'd2); chk("dec_wrap", q_a, 32'hFFFF); rd_stop();
        wr(2'd2, 2'b11, 16'h5A5A);
        rd_start(2'd2); chk("clr", q_a, 32'h0000); rd_stop();
        rd_start(2'd3); chk("reg3_kept", q_a, 32'h0005); rd_stop();

        // 3: select change while driving inserts one Hi-Z cycle
        rd_start(2'd0);
        chk("drv_reg0", q_a, 32'h1234);
        rd_sel = 2'd1;
        tick();
        chk("switch_hiz", {31'd0, qdrv_a}, 32'd0);
        tick();
        chk("switch_drv", {31'd0, qdrv_a}, 32'd1);
        chk("drv_reg1", q_a, 32'hABCD);
        rd_stop();

        // 4: write to the driven register, no bypass
        rd_start(2'd3);
        in = 16'h0000; wr_sel = 2'd3; wr_op = 2'b01; wr_en = 1'b1;
        #1 chk("wwd_before", q_a, 32'h0005);
        tick();
        wr_en = 1'b0;
        chk("wwd_after", q_a, 32'h0006);
        chk("wwd_drv", {31'd0, qdrv_a}, 32'd1);
        rd_stop();

        // 5: out-of-range selects on the NREGS=3 build
        reset = 1'b0; #2 reset = 1'b1;
        chk("oob_err_clr", {31'd0, err_b}, 32'd0);
        wr(2'd0, 2'b00, 16'h0101);
        wr(2'd1, 2'b00, 16'h0202);
        wr(2'd2, 2'b00, 16'h0303);
        chk("oob_err_pre", {31'd0, err_b}, 32'd0);
        wr(2'd3, 2'b00, 16'h5555);
        chk("oob_err_set", {31'd0, err_b}, 32'd1);
        chk("inrange_no_err", {31'd0, err_a}, 32'd0);
        rd_start(2'd0); chk("oob_r0", q_b, 32'h0101); rd_stop();
        rd_start(2'd1); chk("oob_r1", q_b, 32'h0202); rd_stop();
        rd_start(2'd2); chk("oob_r2", q_b, 32'h0303); rd_stop();
        rd_start(2'd3);
        chk("oob_rd_zero", q_b, 32'h0000);
        chk("oob_rd_drv", {31'd0, qdrv_b}, 32'd1);
        chk("a_reg3_load", q_a, 32'h5555);
        rd_stop();
        tick(); tick(); tick();
        chk("oob_sticky", {31'd0, err_b}, 32'd1);
        reset = 1'b0; #2 reset = 1'b1;
        chk("oob_err_rst", {31'd0, err_b}, 32'd0);

        // 6: abort during TURN on the TURN=3 build, then a full read and reset in DRIVE
        wr(2'd0, 2'b00, 16'h4321);
        rd_en = 1'b1; rd_sel = 2'd0;
        tick(); chk("abort_t0", {31'd0, qdrv_c}, 32'd0);
        tick(); chk("abort_t1", {31'd0, qdrv_c}, 32'd0);
        rd_en = 1'b0;
        tick(); chk("abort_t2", {31'd0, qdrv_c}, 32'd0);
        tick(); chk("abort_t3", {31'd0, qdrv_c}, 32'd0);
        rd_en = 1'b1;
        tick(); chk("t3_lat0", {31'd0, qdrv_c}, 32'd0);
        tick(); chk("t3_lat1", {31'd0, qdrv_c}, 32'd0);
        tick(); chk("t3_lat2", {31'd0, qdrv_c}, 32'd0);
        tick(); chk("t3_lat3", {31'd0, qdrv_c}, 32'd1);
        chk("t3_data", q_c, 32'h4321);
        #2 reset = 1'b0;
        #1 chk("t3_async_rst", {31'd0, qdrv_c}, 32'd0);
        #1 reset = 1'b1; rd_en = 1'b0;
        tick();
        rd_start(2'd0); chk("post_rst_reg0", q_a, 32'h0000); rd_stop();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
